// File: rtl/axi4_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_chk_pkg
//  Description : Shared types and helpers for the AXI4 protocol checker.
//                Error bit indices, AXI4 burst/response encodings and a
//                lowest-set-bit helper used to report the first error.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4_chk_pkg;

    localparam int ERR_W = 8;

    // Bit positions inside err_vec / err_pulse
    typedef enum logic [2:0] {
        ERR_AW_STABLE   = 3'd0,
        ERR_AR_STABLE   = 3'd1,
        ERR_W_STABLE    = 3'd2,
        ERR_WLAST       = 3'd3,
        ERR_RLAST       = 3'd4,
        ERR_ORPHAN_RESP = 3'd5,
        ERR_OUTST_OVF   = 3'd6,
        ERR_TIMEOUT     = 3'd7
    } err_idx_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_err(input logic [ERR_W-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_chk_len_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_chk_len_fifo
//  Description : Synchronous FIFO holding AWLEN of accepted write bursts
//                whose data phase is not yet complete. Supports push and
//                pop in the same cycle; push when full / pop when empty
//                are ignored.
//  Ports       : clk, rst_n (sync, active low), push/din, pop/dout,
//                full, empty, count
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_chk_len_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_FULL);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_protocol_checker.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_protocol_checker
//  Description : Passive AXI4 link checker. Flags payload instability,
//                WLAST/RLAST misuse, orphan write responses, outstanding
//                overflow and VALID-without-READY timeouts.
//  Ports       : clk, rst_n (sync, active low)
//                AW/W/B/AR/R channel signals (all inputs, tapped)
//                clr       - clears err_vec, first_err, err_cnt
//                err_vec   - sticky error flags
//                err_pulse - errors detected in the previous cycle
//                first_err - lowest bit of first nonzero error pulse
//                err_cnt   - saturating count of error cycles
//                wr_outst / rd_outst - outstanding bursts
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_protocol_checker
    import axi4_chk_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MAX_OUTST = 8,
    parameter int TIMEOUT   = 1024,
    parameter int ERRCNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          awvalid,
    input  logic                          awready,
    input  logic [ID_W-1:0]               awid,
    input  logic [ADDR_W-1:0]             awaddr,
    input  logic [7:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic                          wvalid,
    input  logic                          wready,
    input  logic                          wlast,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W/8-1:0]           wstrb,
    input  logic                          bvalid,
    input  logic                          bready,
    input  logic [ID_W-1:0]               bid,
    input  logic [1:0]                    bresp,
    input  logic                          arvalid,
    input  logic                          arready,
    input  logic [ID_W-1:0]               arid,
    input  logic [ADDR_W-1:0]             araddr,
    input  logic [7:0]                    arlen,
    input  logic [2:0]                    arsize,
    input  logic [1:0]                    arburst,
    input  logic                          rvalid,
    input  logic                          rready,
    input  logic                          rlast,
    input  logic [ID_W-1:0]               rid,
    input  logic [DATA_W-1:0]             rdata,
    input  logic [1:0]                    rresp,
    input  logic                          clr,
    output logic [ERR_W-1:0]              err_vec,
    output logic [ERR_W-1:0]              err_pulse,
    output logic [2:0]                    first_err,
    output logic [ERRCNT_W-1:0]           err_cnt,
    output logic [$clog2(MAX_OUTST):0]    wr_outst,
    output logic [$clog2(MAX_OUTST):0]    rd_outst
);

    localparam int                  c_OUT_W   = $clog2(MAX_OUTST) + 1;
    localparam int                  c_TO_W    = $clog2(TIMEOUT) + 1;
    localparam int                  c_NCH     = 5;
    localparam int                  c_AW_W    = ID_W + ADDR_W + 8 + 3 + 2;
    localparam int                  c_W_W     = DATA_W + DATA_W / 8 + 1;
    localparam logic [c_OUT_W-1:0]  c_OUT_MAX = c_OUT_W'(MAX_OUTST);
    localparam logic [c_TO_W-1:0]   c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0]   c_TO_FULL = c_TO_W'(TIMEOUT);

    // Response/read-data payloads carry no checked property here.
    logic w_unused;
    assign w_unused = ^{bid, bresp, rid, rdata, rresp};

    // ---------------------------------------------------------------- handshakes
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_b_hs  = bvalid && bready;
    assign w_ar_hs = arvalid && arready;
    assign w_r_hs  = rvalid && rready;

    logic [c_OUT_W-1:0] r_wr_outst, r_rd_outst, r_wr_cmpl;
    logic w_aw_ovf, w_ar_ovf, w_aw_push, w_ar_inc, w_b_ok, w_r_dec;
    assign w_aw_ovf  = w_aw_hs && (r_wr_outst == c_OUT_MAX);
    assign w_ar_ovf  = w_ar_hs && (r_rd_outst == c_OUT_MAX);
    assign w_aw_push = w_aw_hs && !w_aw_ovf;
    assign w_ar_inc  = w_ar_hs && !w_ar_ovf;
    assign w_b_ok    = w_b_hs && (r_wr_cmpl != '0);
    assign w_r_dec   = w_r_hs && rlast && (r_rd_outst != '0);

    // ---------------------------------------------------------------- write length
    logic       w_fifo_empty, w_fifo_full, w_fifo_push, w_fifo_pop;
    logic [7:0] w_fifo_head, w_w_len, r_beat;
    logic [c_OUT_W-1:0] w_fifo_count;
    logic       w_w_have, w_w_is_final, w_w_final;

    // With no queued burst, an AW accepted this very cycle supplies the length.
    assign w_w_have     = !w_fifo_empty || w_aw_push;
    assign w_w_len      = w_fifo_empty ? awlen : w_fifo_head;
    assign w_w_is_final = (r_beat == w_w_len);
    assign w_w_final    = w_w_hs && w_w_have && w_w_is_final;
    // A single-beat burst bypassing an empty FIFO is never stored.
    assign w_fifo_push  = w_aw_push && !(w_fifo_empty && w_w_final);
    assign w_fifo_pop   = w_w_final && !w_fifo_empty;

    axi4_chk_len_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (8)
    ) u_len_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fifo_push),
        .din   (awlen),
        .pop   (w_fifo_pop),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    logic w_unused_fifo;
    assign w_unused_fifo = ^{w_fifo_full, w_fifo_count};

    // ---------------------------------------------------------------- stability
    logic              r_aw_hold, r_ar_hold, r_w_hold;
    logic [c_AW_W-1:0] r_aw_snap, r_ar_snap, w_aw_pay, w_ar_pay;
    logic [c_W_W-1:0]  r_w_snap, w_w_pay;
    assign w_aw_pay = {awid, awaddr, awlen, awsize, awburst};
    assign w_ar_pay = {arid, araddr, arlen, arsize, arburst};
    assign w_w_pay  = {wdata, wstrb, wlast};

    // ---------------------------------------------------------------- timeouts
    logic [c_NCH-1:0] w_vld, w_rdy, w_to_fire;
    assign w_vld = {rvalid, bvalid, arvalid, wvalid, awvalid};
    assign w_rdy = {rready, bready, arready, wready, awready};

    generate
        for (genvar g = 0; g < c_NCH; g++) begin : g_timeout
            logic [c_TO_W-1:0] r_cnt;
            logic              w_stall;
            assign w_stall = w_vld[g] && !w_rdy[g];
            // Counter parks at TIMEOUT so the flag fires once per stall.
            always_ff @(posedge clk) begin
                if (!rst_n || !w_stall) r_cnt <= '0;
                else if (r_cnt != c_TO_FULL) r_cnt <= r_cnt + 1'b1;
            end
            assign w_to_fire[g] = w_stall && (r_cnt == c_TO_LAST);
        end
    endgenerate

    // ---------------------------------------------------------------- error detect
    logic [ERR_W-1:0] w_err;
    always_comb begin
        w_err                  = '0;
        w_err[ERR_AW_STABLE]   = r_aw_hold && (!awvalid || (w_aw_pay != r_aw_snap));
        w_err[ERR_AR_STABLE]   = r_ar_hold && (!arvalid || (w_ar_pay != r_ar_snap));
        w_err[ERR_W_STABLE]    = r_w_hold && (!wvalid || (w_w_pay != r_w_snap));
        w_err[ERR_WLAST]       = w_w_hs && (!w_w_have || (wlast != w_w_is_final));
        w_err[ERR_RLAST]       = w_r_hs && (r_rd_outst == '0);
        w_err[ERR_ORPHAN_RESP] = w_b_hs && (r_wr_cmpl == '0);
        w_err[ERR_OUTST_OVF]   = w_aw_ovf || w_ar_ovf;
        w_err[ERR_TIMEOUT]     = |w_to_fire;
    end

    // ---------------------------------------------------------------- state
    logic [ERR_W-1:0]    r_err_vec, r_err_pulse;
    logic [2:0]          r_first_err;
    logic [ERRCNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_hold   <= 1'b0;
            r_ar_hold   <= 1'b0;
            r_w_hold    <= 1'b0;
            r_aw_snap   <= '0;
            r_ar_snap   <= '0;
            r_w_snap    <= '0;
            r_beat      <= '0;
            r_wr_outst  <= '0;
            r_rd_outst  <= '0;
            r_wr_cmpl   <= '0;
            r_err_vec   <= '0;
            r_err_pulse <= '0;
            r_first_err <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_aw_hold <= awvalid && !awready;
            r_ar_hold <= arvalid && !arready;
            r_w_hold  <= wvalid && !wready;
            r_aw_snap <= w_aw_pay;
            r_ar_snap <= w_ar_pay;
            r_w_snap  <= w_w_pay;

            if (w_w_hs && w_w_have) r_beat <= w_w_final ? 8'd0 : r_beat + 8'd1;

            case ({w_aw_push, w_b_ok})
                2'b10:   r_wr_outst <= r_wr_outst + 1'b1;
                2'b01:   r_wr_outst <= r_wr_outst - 1'b1;
                default: ;
            endcase
            case ({w_ar_inc, w_r_dec})
                2'b10:   r_rd_outst <= r_rd_outst + 1'b1;
                2'b01:   r_rd_outst <= r_rd_outst - 1'b1;
                default: ;
            endcase
            case ({w_w_final, w_b_ok})
                2'b10:   r_wr_cmpl <= r_wr_cmpl + 1'b1;
                2'b01:   r_wr_cmpl <= r_wr_cmpl - 1'b1;
                default: ;
            endcase

            r_err_pulse <= w_err;
            // A clear coinciding with a new error keeps that error.
            if (clr) begin
                r_err_vec   <= w_err;
                r_first_err <= lowest_err(w_err);
                r_err_cnt   <= (|w_err) ? ERRCNT_W'(1) : '0;
            end else begin
                r_err_vec <= r_err_vec | w_err;
                if ((r_err_vec == '0) && (|w_err)) r_first_err <= lowest_err(w_err);
                if ((|w_err) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign err_vec   = r_err_vec;
    assign err_pulse = r_err_pulse;
    assign first_err = r_first_err;
    assign err_cnt   = r_err_cnt;
    assign wr_outst  = r_wr_outst;
    assign rd_outst  = r_rd_outst;

endmodule
`default_nettype wire

// File: tb/tb_axi4_protocol_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_protocol_checker
//  Description : Self-checking bench for axi4_protocol_checker: directed
//                error scenarios plus randomized legal traffic compared with
//                a transaction-level model of outstanding bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_protocol_checker;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int ID_W      = 4;
    localparam int MAX_OUTST = 8;
    localparam int TIMEOUT   = 16;
    localparam int ERRCNT_W  = 4;
    localparam int OW        = $clog2(MAX_OUTST) + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast, clr;
    logic [ID_W-1:0]     awid, bid, arid, rid;
    logic [ADDR_W-1:0]   awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [2:0]          awsize, arsize;
    logic [1:0]          awburst, arburst, bresp, rresp;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [7:0]          err_vec, err_pulse;
    logic [2:0]          first_err;
    logic [ERRCNT_W-1:0] err_cnt;
    logic [OW-1:0]       wr_outst, rd_outst;

    always #5 clk = ~clk;

    axi4_protocol_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
        .rdata(rdata), .rresp(rresp),
        .clr(clr), .err_vec(err_vec), .err_pulse(err_pulse), .first_err(first_err),
        .err_cnt(err_cnt), .wr_outst(wr_outst), .rd_outst(rd_outst)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awvalid = 0; awready = 0; awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'd1;
        wvalid = 0; wready = 0; wlast = 0; wdata = '0; wstrb = '1;
        bvalid = 0; bready = 0; bid = '0; bresp = '0;
        arvalid = 0; arready = 0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'd1;
        rvalid = 0; rready = 0; rlast = 0; rid = '0; rdata = '0; rresp = '0;
        clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    // Randomized-phase model: transaction counts and burst-length queues.
    int m_wr_out, m_rd_out, m_cmpl, wbeat, rbeat;
    int wq[$];
    int rq[$];
    int st_aw, st_w, st_b, st_ar, st_r;
    int pulses, first_k;

    initial begin
        do_reset();
        // ---------------- reset state and idle
        check_val("rst_err_vec", err_vec, 0);
        check_val("rst_err_pulse", err_pulse, 0);
        check_val("rst_err_cnt", err_cnt, 0);
        check_val("rst_wr_outst", wr_outst, 0);
        check_val("rst_rd_outst", rd_outst, 0);
        check_val("rst_first_err", first_err, 0);
        repeat (50) step();
        check_val("idle_err_vec", err_vec, 0);
        check_val("idle_err_cnt", err_cnt, 0);
        check_val("idle_outst", {wr_outst, rd_outst}, 0);

        // ---------------- legal 4-beat write
        awvalid = 1; awready = 1; awlen = 8'd3; awaddr = 32'h200;
        step();
        awvalid = 0; awready = 0;
        check_val("wr_outst_after_aw", wr_outst, 1);
        for (int b = 0; b < 4; b++) begin
            wvalid = 1; wready = 1; wlast = (b == 3); wdata = {$urandom, $urandom};
            step();
        end
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 1; bready = 1;
        step();
        bvalid = 0; bready = 0;
        step();
        check_val("legal_wr_err_vec", err_vec, 0);
        check_val("legal_wr_outst", wr_outst, 0);

        // ---------------- AW payload change under stall
        do_reset();
        awvalid = 1; awready = 0; awaddr = 32'h100;
        step();
        awaddr = 32'h104; awready = 1;
        step();
        awvalid = 0; awready = 0;
        check_val("aw_stab_pulse", err_pulse, 8'h01);
        check_val("aw_stab_vec", err_vec, 8'h01);
        check_val("aw_stab_first", first_err, 0);
        check_val("aw_stab_cnt", err_cnt, 1);
        step();
        check_val("aw_stab_pulse_clear", err_pulse, 0);
        check_val("aw_stab_cnt_hold", err_cnt, 1);

        // ---------------- early WLAST then orphan B
        do_reset();
        awvalid = 1; awready = 1; awlen = 8'd1;
        step();
        awvalid = 0; awready = 0;
        wvalid = 1; wready = 1; wlast = 1;
        step();
        wvalid = 0; wready = 0; wlast = 0;
        check_val("wlast_vec", err_vec, 8'h08);
        check_val("wlast_first", first_err, 3);
        bvalid = 1; bready = 1;
        step();
        bvalid = 0; bready = 0;
        check_val("orphan_vec", err_vec, 8'h28);
        check_val("orphan_first", first_err, 3);
        check_val("orphan_cnt", err_cnt, 2);

        // ---------------- read outstanding overflow
        do_reset();
        arvalid = 1; arready = 1;
        for (int i = 1; i <= 9; i++) begin
            araddr = $urandom;
            step();
            if (i == 8) begin
                check_val("ar8_rd_outst", rd_outst, 8);
                check_val("ar8_err_vec", err_vec, 0);
            end
        end
        arvalid = 0; arready = 0;
        check_val("ovf_vec", err_vec, 8'h40);
        check_val("ovf_rd_outst", rd_outst, 8);
        check_val("ovf_first", first_err, 6);

        // ---------------- R timeout, then clear
        do_reset();
        rvalid = 1; rready = 0;
        pulses = 0; first_k = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (err_pulse[7]) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        rvalid = 0;
        step();
        check_val("to_pulse_count", pulses, 1);
        check_val("to_pulse_cycle", first_k, TIMEOUT);
        check_val("to_vec", err_vec, 8'h80);
        check_val("to_cnt", err_cnt, 1);
        clr = 1;
        step();
        clr = 0;
        check_val("clr_vec", err_vec, 0);
        check_val("clr_cnt", err_cnt, 0);

        // ---------------- clr with a new error, then counter saturation
        rvalid = 1; rready = 1; rlast = 1;
        step();
        clr = 1;
        step();
        clr = 0;
        check_val("clr_new_vec", err_vec, 8'h10);
        check_val("clr_new_cnt", err_cnt, 1);
        check_val("clr_new_first", first_err, 4);
        repeat (20) step();
        rvalid = 0; rready = 0; rlast = 0;
        check_val("cnt_saturate", err_cnt, (1 << ERRCNT_W) - 1);

        // ---------------- same-cycle AW+W bypass and net-zero counters
        do_reset();
        awvalid = 1; awready = 1; awlen = 8'd0;
        wvalid = 1; wready = 1; wlast = 1;
        step();
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
        check_val("bypass_err", err_vec, 0);
        check_val("bypass_wr_outst", wr_outst, 1);
        bvalid = 1; bready = 1;
        step();
        bvalid = 0; bready = 0;
        check_val("bypass_b_outst", wr_outst, 0);
        arvalid = 1; arready = 1;
        step();
        rvalid = 1; rready = 1; rlast = 1;
        step();
        check_val("netzero_rd_outst", rd_outst, 1);
        arvalid = 0; arready = 0;
        step();
        rvalid = 0; rready = 0; rlast = 0;
        check_val("netzero_drain", rd_outst, 0);
        check_val("netzero_err", err_vec, 0);

        // ---------------- randomized legal traffic
        do_reset();
        m_wr_out = 0; m_rd_out = 0; m_cmpl = 0; wbeat = 0; rbeat = 0;
        wq.delete(); rq.delete();
        st_aw = 0; st_w = 0; st_b = 0; st_ar = 0; st_r = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
            if (!(awvalid && !awready)) begin
                awvalid = (m_wr_out < MAX_OUTST) && ($urandom_range(0, 2) == 0);
                awid = ID_W'($urandom); awaddr = $urandom; awlen = 8'($urandom_range(0, 3));
            end
            awready = (st_aw >= 3) || ($urandom_range(0, 1) == 1);
            if (!(wvalid && !wready)) begin
                wvalid = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
                wlast  = (wq.size() > 0) && (wbeat == wq[0]);
                wdata  = {$urandom, $urandom};
                wstrb  = DATA_W'($urandom);
            end
            wready = (st_w >= 3) || ($urandom_range(0, 1) == 1);
            if (!(bvalid && !bready)) begin
                bvalid = (m_cmpl > 0) && ($urandom_range(0, 1) == 1);
                bid = ID_W'($urandom); bresp = 2'($urandom);
            end
            bready = (st_b >= 3) || ($urandom_range(0, 1) == 1);
            if (!(arvalid && !arready)) begin
                arvalid = (m_rd_out < MAX_OUTST) && ($urandom_range(0, 2) == 0);
                arid = ID_W'($urandom); araddr = $urandom; arlen = 8'($urandom_range(0, 3));
            end
            arready = (st_ar >= 3) || ($urandom_range(0, 1) == 1);
            if (!(rvalid && !rready)) begin
                rvalid = (rq.size() > 0) && ($urandom_range(0, 1) == 1);
                rlast  = (rq.size() > 0) && (rbeat == rq[0]);
                rdata  = {$urandom, $urandom};
            end
            rready = (st_r >= 3) || ($urandom_range(0, 1) == 1);

            aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            step();

            st_aw = (awvalid && !awready) ? st_aw + 1 : 0;
            st_w  = (wvalid && !wready)   ? st_w + 1  : 0;
            st_b  = (bvalid && !bready)   ? st_b + 1  : 0;
            st_ar = (arvalid && !arready) ? st_ar + 1 : 0;
            st_r  = (rvalid && !rready)   ? st_r + 1  : 0;
            if (aw_hs) begin m_wr_out++; wq.push_back(int'(awlen)); end
            if (w_hs) begin
                if (wlast) begin void'(wq.pop_front()); wbeat = 0; m_cmpl++; end
                else wbeat++;
            end
            if (b_hs) begin m_cmpl--; m_wr_out--; end
            if (ar_hs) begin m_rd_out++; rq.push_back(int'(arlen)); end
            if (r_hs) begin
                if (rlast) begin void'(rq.pop_front()); rbeat = 0; m_rd_out--; end
                else rbeat++;
            end

            check_val("rnd_err_vec", err_vec, 0);
            check_val("rnd_wr_outst", wr_outst, m_wr_out);
            check_val("rnd_rd_outst", rd_outst, m_rd_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
